program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Datapath program counter directly downstream of the control-unit decoders, including the CBZ/CBNZ decoder.
- Consumes the control-word PC fields (databus_program_counter_enable, program_counter_function_select, program_counter_input_select) and the decoder's 64-bit sign-extended constant.
- Holds the architectural PC and drives the instruction-memory address.
- Optionally drives PC+4 onto the shared data bus for BL link writes.
- Resolves conditional branches from a live condition input and flags misaligned targets.

Parameters:
RESET_VECTOR, 64'h0, PC value loaded on reset
WIDTH, 64, PC and data bus width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
function_select  input  2  program_counter_function_select from control word
input_select  input  1  program_counter_input_select from control word
databus_enable  input  1  databus_program_counter_enable; PC+4 drives data_bus_out
constant  input  64  sign-extended word offset from decoder
data_bus_in  input  64  shared data bus value (register target for BR)
branch_condition  input  1  1 = conditional branch taken (e.g. CBZ zero / CBNZ non-zero)
stall  input  1  1 = freeze PC this cycle
pc  output  64  current PC / instruction address
pc_plus_4  output  64  pc + 4 (combinational)
data_bus_out  output  64  pc_plus_4 when databus_enable, else 64'hZ
misaligned  output  1  sticky: a loaded target had bits [1:0] != 0

Behaviour:
- Reset (reset=0, asynchronous): pc <= RESET_VECTOR, misaligned <= 0. Held while reset low. Deassertion is synchronous to the next clock edge.
- All PC updates occur on the rising clock edge. pc_plus_4 and data_bus_out are combinational from pc.
- next_pc selection, function_select/input_select:
  - 00/x: hold.
  - 01/x: pc+4.
  - 10/0: data_bus_in (BR).
  - 10/1: pc + (constant<<2), unconditional B/BL.
  - 11/1: pc + (constant<<2) if branch_condition, else pc+4 (CBZ/CBNZ/B.cond).
  - 11/0: pc+4 (not taken, reserved).
- Offset arithmetic: constant shifted left 2 (bits shifted out are discarded), added modulo 2^64. Wrap-around is silent: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- stall=1: pc holds regardless of function_select. misaligned is not updated. Takes priority over all selects.
- Misaligned: if the selected next_pc has [1:0] != 0 (only possible via 10/0), pc still loads the value and misaligned sets to 1. It stays set until reset.
- data_bus_out: high-Z whenever databus_enable=0. Never drives during reset.
- branch_condition is sampled only in the cycle function_select=11. It is ignored otherwise.
- Reset asserted mid-cycle overrides any pending update. The first post-reset edge applies the then-current inputs.
- Latency: one cycle from control inputs to pc. Zero cycles for pc_plus_4 and data_bus_out.

Test Plan:
1. Reset low, then high. Apply fs=01 for 3 edges -> pc = 0, 4, 8, 12. pc_plus_4 = 16.
2. pc=0x100, fs=11, is=1, constant=64'hFFFF_FFFF_FFFF_FFFE, branch_condition=1 -> pc=0xF8. Repeat with branch_condition=0 -> pc=0x104.
3. pc=0x40, fs=10, is=0, data_bus_in=0x2002 -> pc=0x2002, misaligned=1. Then fs=01 -> pc=0x2006, misaligned remains 1.
4. fs=01, stall=1 for 2 edges -> pc unchanged. databus_enable=1 -> data_bus_out=pc+4. databus_enable=0 -> data_bus_out=Z.
5. pc=64'hFFFF_FFFF_FFFF_FFFC, fs=01 -> pc=0 (wrap).
6. Assert reset between edges while fs=10 is pending -> pc=RESET_VECTOR immediately, misaligned=0, no load on the following edge while reset is low.

Source files
------------

// File: rtl/program_counter.sv
// Architectural program counter: selects the next instruction address from the
// control word, drives PC+4 onto the shared bus for link writes, and flags misaligned targets.
module program_counter #(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       function_select,
  input  logic             input_select,
  input  logic             databus_enable,
  input  logic [WIDTH-1:0] constant,
  input  logic [WIDTH-1:0] data_bus_in,
  input  logic             branch_condition,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] data_bus_out,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] INSTR_BYTES = WIDTH'(4);

  typedef enum logic [1:0] {
    FS_HOLD = 2'b00,
    FS_INCR = 2'b01,
    FS_JUMP = 2'b10,
    FS_COND = 2'b11
  } pc_func_e;

  pc_func_e         func;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] word_offset;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] seq_pc;
  logic             misaligned_q, misaligned_d;

  assign func          = pc_func_e'(function_select);
  assign word_offset   = constant << 2;
  assign branch_target = pc_q + word_offset;
  assign seq_pc        = pc_q + INSTR_BYTES;

  // Next-PC select; a stall freezes both the PC and the sticky flag.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (!stall) begin
      unique case (func)
        FS_HOLD: pc_d = pc_q;
        FS_INCR: pc_d = seq_pc;
        FS_JUMP: pc_d = input_select ? branch_target : data_bus_in;
        FS_COND: pc_d = (input_select && branch_condition) ? branch_target : seq_pc;
        default: pc_d = pc_q;
      endcase
      if (pc_d[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = misaligned_q;
  assign pc_plus_4  = seq_pc;

  // Link value goes on the shared bus only when enabled and never while in reset.
  assign data_bus_out = (databus_enable && reset) ? seq_pc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: a reference model pushes expected PC/flag
// values into a scoreboard queue and each clock edge pops and compares them.
module tb_program_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  function_select;
  logic        input_select;
  logic        databus_enable;
  logic [63:0] constant;
  logic [63:0] data_bus_in;
  logic        branch_condition;
  logic        stall;
  logic [63:0] pc;
  logic [63:0] pc_plus_4;
  logic [63:0] data_bus_out;
  logic        misaligned;

  program_counter #(.WIDTH(64), .RESET_VECTOR(64'h0)) dut (
    .clock            (clock),
    .reset            (reset),
    .function_select  (function_select),
    .input_select     (input_select),
    .databus_enable   (databus_enable),
    .constant         (constant),
    .data_bus_in      (data_bus_in),
    .branch_condition (branch_condition),
    .stall            (stall),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .data_bus_out     (data_bus_out),
    .misaligned       (misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m_pc  = 64'h0;
  logic        m_mis = 1'b0;

  function automatic logic [63:0] model_next(input logic [1:0] fs, input logic is,
                                             input logic [63:0] cur, input logic [63:0] k,
                                             input logic [63:0] dbin, input logic bc,
                                             input logic st);
    logic [63:0] tgt;
    tgt = cur + 64'(k * 64'd4);
    if (st) return cur;
    case (fs)
      2'b00:   return cur;
      2'b01:   return cur + 64'd4;
      2'b10:   return is ? tgt : dbin;
      default: return (is && bc) ? tgt : cur + 64'd4;
    endcase
  endfunction

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bus_released(input string tag);
    n_cmp++;
    assert ((data_bus_out === {64{1'bz}}) || (data_bus_out === 64'h0)) else begin
      n_err++;
      $error("FAIL %s: observed %h expected released bus", tag, data_bus_out);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk64({e.tag, "_pc"}, pc, e.pc);
      chk64({e.tag, "_mis"}, 64'(misaligned), 64'(e.mis));
      chk64({e.tag, "_pc4"}, pc_plus_4, e.pc + 64'd4);
    end
  endtask

  // Drive one cycle of control, predict the result, then compare after the edge.
  task automatic step(input string tag, input logic [1:0] fs, input logic is,
                      input logic [63:0] k, input logic [63:0] dbin,
                      input logic bc, input logic st);
    exp_t e;
    function_select  = fs;
    input_select     = is;
    constant         = k;
    data_bus_in      = dbin;
    branch_condition = bc;
    stall            = st;
    e.tag = tag;
    e.pc  = model_next(fs, is, m_pc, k, dbin, bc, st);
    e.mis = m_mis | (!st && (e.pc[1:0] != 2'b00));
    m_pc  = e.pc;
    m_mis = e.mis;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; function_select = 2'b00; input_select = 1'b0; databus_enable = 1'b1;
    constant = '0; data_bus_in = '0; branch_condition = 1'b0; stall = 1'b0;
    #1 reset = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk64("rst_pc", pc, 64'h0);
    chk64("rst_mis", 64'(misaligned), 64'h0);
    chk_bus_released("rst_bus");
    databus_enable = 1'b0;
    reset = 1'b1;

    // Sequential fetch
    step("inc1", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step("inc2", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step("inc3", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk64("inc_pc4", pc_plus_4, 64'd16);
    step("hold", 2'b00, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Conditional branch, taken and not taken, negative offset
    step("br100a", 2'b10, 1'b0, 64'h0, 64'h100, 1'b0, 1'b0);
    step("cbz_t", 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b1, 1'b0);
    chk64("cbz_t_abs", pc, 64'hF8);
    step("br100b", 2'b10, 1'b0, 64'h0, 64'h100, 1'b0, 1'b0);
    step("cbz_n", 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 1'b0);
    chk64("cbz_n_abs", pc, 64'h104);
    step("resv", 2'b11, 1'b0, 64'h7, 64'h0, 1'b1, 1'b0);
    step("b_unc", 2'b10, 1'b1, 64'h3, 64'hDEAD, 1'b0, 1'b0);
    step("incnc", 2'b01, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Misaligned register target, flag is sticky
    step("br40", 2'b10, 1'b0, 64'h0, 64'h40, 1'b0, 1'b0);
    step("br2002", 2'b10, 1'b0, 64'h0, 64'h2002, 1'b0, 1'b0);
    chk64("mis_set", 64'(misaligned), 64'h1);
    step("mis_inc", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk64("mis_inc_abs", pc, 64'h2006);

    // Stall and link-bus drive
    step("stall1", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    step("stall2", 2'b10, 1'b0, 64'h0, 64'h123, 1'b0, 1'b1);
    databus_enable = 1'b1; #1;
    chk64("bus_drv", data_bus_out, m_pc + 64'd4);
    databus_enable = 1'b0; #1;
    chk_bus_released("bus_off");

    // Wrap-around
    step("brtop", 2'b10, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    step("wrap", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk64("wrap_abs", pc, 64'h0);
    step("pre_rst", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    // Mid-cycle reset with a load pending
    function_select = 2'b10; input_select = 1'b0; data_bus_in = 64'h555; databus_enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    m_pc = 64'h0; m_mis = 1'b0;
    chk64("midrst_pc", pc, 64'h0);
    chk64("midrst_mis", 64'(misaligned), 64'h0);
    chk_bus_released("midrst_bus");
    @(posedge clock); #1;
    chk64("rst_hold_pc", pc, 64'h0);
    databus_enable = 1'b0;
    reset = 1'b1;
    step("post_rst", 2'b01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
